// File: rtl/mc_controller_pkg.sv
// ============================================================================
// Module      : mc_controller_pkg
// Description : Shared encodings for the multicycle MIPS control path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_controller_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      RTEXE  = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_j     = 6'b000010;

   localparam logic [5:0] c_fn_add = 6'b100000;
   localparam logic [5:0] c_fn_sub = 6'b100010;
   localparam logic [5:0] c_fn_and = 6'b100100;
   localparam logic [5:0] c_fn_or  = 6'b100101;
   localparam logic [5:0] c_fn_slt = 6'b101010;

   localparam logic [1:0] c_aluop_add   = 2'b00;
   localparam logic [1:0] c_aluop_sub   = 2'b01;
   localparam logic [1:0] c_aluop_funct = 2'b10;

   localparam logic [2:0] c_alu_add = 3'b010;
   localparam logic [2:0] c_alu_sub = 3'b110;
   localparam logic [2:0] c_alu_and = 3'b000;
   localparam logic [2:0] c_alu_or  = 3'b001;
   localparam logic [2:0] c_alu_slt = 3'b111;

   localparam logic [1:0] c_srcb_rt    = 2'b00;
   localparam logic [1:0] c_srcb_four  = 2'b01;
   localparam logic [1:0] c_srcb_imm   = 2'b10;
   localparam logic [1:0] c_srcb_immsh = 2'b11;

   localparam logic [1:0] c_pc_alu    = 2'b00;
   localparam logic [1:0] c_pc_aluout = 2'b01;
   localparam logic [1:0] c_pc_jump   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_aludec.sv
// ============================================================================
// Module      : mc_aludec
// Description : ALU function decode from aluop and R-type funct field.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_aludec
   import mc_controller_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   // Unknown funct and the unused aluop code fall back to AND so nothing goes X.
   always_comb begin
      alucontrol = c_alu_and;
      case (aluop)
         c_aluop_add: alucontrol = c_alu_add;
         c_aluop_sub: alucontrol = c_alu_sub;
         c_aluop_funct: begin
            case (funct)
               c_fn_add: alucontrol = c_alu_add;
               c_fn_sub: alucontrol = c_alu_sub;
               c_fn_and: alucontrol = c_alu_and;
               c_fn_or:  alucontrol = c_alu_or;
               c_fn_slt: alucontrol = c_alu_slt;
               default:  alucontrol = c_alu_and;
            endcase
         end
         default: alucontrol = c_alu_and;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
// Module      : mc_controller
// Description : Moore control FSM sequencing the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_controller
   import mc_controller_pkg::*;
#(
   parameter int STATE_W = 4,
   parameter bit BNE_EN  = 1'b0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               pcen,
   output logic               iord,
   output logic               irwrite,
   output logic               memwrite,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [2:0]         alucontrol,
   output logic               instr_done,
   output logic               illegal,
   output logic [STATE_W-1:0] dbg_state
);

   state_t     r_state;
   state_t     w_next;
   logic       r_is_bne;

   logic       w_iord;
   logic       w_irwrite;
   logic       w_memwrite;
   logic       w_regdst;
   logic       w_memtoreg;
   logic       w_regwrite;
   logic       w_alusrca;
   logic [1:0] w_alusrcb;
   logic [1:0] w_pcsrc;
   logic [1:0] w_aluop;
   logic       w_pcwrite;
   logic       w_branch;
   logic       w_done;
   logic       w_illegal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Branch sense is latched in DECODE so op is not needed again in BRANCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_bne <= 1'b0;
      end else if (r_state == DECODE) begin
         r_is_bne <= BNE_EN && (op == c_op_bne);
      end
   end

   always_comb begin
      w_next     = FETCH;
      w_iord     = 1'b0;
      w_irwrite  = 1'b0;
      w_memwrite = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = c_srcb_rt;
      w_pcsrc    = c_pc_alu;
      w_aluop    = c_aluop_add;
      w_pcwrite  = 1'b0;
      w_branch   = 1'b0;
      w_done     = 1'b0;
      w_illegal  = 1'b0;
      case (r_state)
         FETCH: begin
            w_alusrcb = c_srcb_four;
            w_irwrite = 1'b1;
            w_pcwrite = 1'b1;
            w_next    = DECODE;
         end
         DECODE: begin
            w_alusrcb = c_srcb_immsh;
            case (op)
               c_op_lw, c_op_sw: w_next = MEMADR;
               c_op_rtype:       w_next = RTEXE;
               c_op_beq:         w_next = BRANCH;
               c_op_addi:        w_next = ADDIEX;
               c_op_j:           w_next = JUMP;
               c_op_bne: begin
                  if (BNE_EN) begin
                     w_next = BRANCH;
                  end else begin
                     w_illegal = 1'b1;
                     w_done    = 1'b1;
                  end
               end
               default: begin
                  w_illegal = 1'b1;
                  w_done    = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = c_srcb_imm;
            w_next    = (op == c_op_lw) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            w_iord = 1'b1;
            w_next = MEMWB;
         end
         MEMWB: begin
            w_memtoreg = 1'b1;
            w_regwrite = 1'b1;
            w_done     = 1'b1;
         end
         MEMWR: begin
            w_iord     = 1'b1;
            w_memwrite = 1'b1;
            w_done     = 1'b1;
         end
         RTEXE: begin
            w_alusrca = 1'b1;
            w_aluop   = c_aluop_funct;
            w_next    = ALUWB;
         end
         ALUWB: begin
            w_regdst   = 1'b1;
            w_regwrite = 1'b1;
            w_done     = 1'b1;
         end
         BRANCH: begin
            w_alusrca = 1'b1;
            w_aluop   = c_aluop_sub;
            w_pcsrc   = c_pc_aluout;
            w_branch  = 1'b1;
            w_done    = 1'b1;
         end
         ADDIEX: begin
            w_alusrca = 1'b1;
            w_alusrcb = c_srcb_imm;
            w_next    = ADDIWB;
         end
         ADDIWB: begin
            w_regwrite = 1'b1;
            w_done     = 1'b1;
         end
         JUMP: begin
            w_pcsrc   = c_pc_jump;
            w_pcwrite = 1'b1;
            w_done    = 1'b1;
         end
         default: w_next = FETCH;
      endcase
   end

   mc_aludec u_aludec (
      .aluop      (w_aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   // Enables are gated by reset directly so an async abort blocks writes at once.
   assign pcen       = ~reset & (w_pcwrite | (w_branch & (zero ^ r_is_bne)));
   assign irwrite    = ~reset & w_irwrite;
   assign memwrite   = ~reset & w_memwrite;
   assign regwrite   = ~reset & w_regwrite;
   assign instr_done = ~reset & w_done;
   assign illegal    = ~reset & w_illegal;

   assign iord      = w_iord;
   assign regdst    = w_regdst;
   assign memtoreg  = w_memtoreg;
   assign alusrca   = w_alusrca;
   assign alusrcb   = w_alusrcb;
   assign pcsrc     = w_pcsrc;
   assign dbg_state = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// Module      : tb_mc_controller
// Description : Randomized self-checking bench for mc_controller (both BNE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;

   typedef int int_q_t[$];

   logic       clk = 1'b0;
   logic       reset_a = 1'b1;
   logic       reset_b = 1'b1;
   logic [5:0] op = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       zero = 1'b0;

   logic       pcen_a, iord_a, irwrite_a, memwrite_a, regdst_a, memtoreg_a;
   logic       regwrite_a, alusrca_a, done_a, illegal_a;
   logic [1:0] alusrcb_a, pcsrc_a;
   logic [2:0] alucontrol_a;
   logic [3:0] state_a;

   logic       pcen_b, iord_b, irwrite_b, memwrite_b, regdst_b, memtoreg_b;
   logic       regwrite_b, alusrca_b, done_b, illegal_b;
   logic [1:0] alusrcb_b, pcsrc_b;
   logic [2:0] alucontrol_b;
   logic [3:0] state_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_controller #(.STATE_W(4), .BNE_EN(1'b0)) dut_a (
      .clk(clk), .reset(reset_a), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen_a), .iord(iord_a), .irwrite(irwrite_a), .memwrite(memwrite_a),
      .regdst(regdst_a), .memtoreg(memtoreg_a), .regwrite(regwrite_a),
      .alusrca(alusrca_a), .alusrcb(alusrcb_a), .pcsrc(pcsrc_a),
      .alucontrol(alucontrol_a), .instr_done(done_a), .illegal(illegal_a),
      .dbg_state(state_a)
   );

   mc_controller #(.STATE_W(4), .BNE_EN(1'b1)) dut_b (
      .clk(clk), .reset(reset_b), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen_b), .iord(iord_b), .irwrite(irwrite_b), .memwrite(memwrite_b),
      .regdst(regdst_b), .memtoreg(memtoreg_b), .regwrite(regwrite_b),
      .alusrca(alusrca_b), .alusrcb(alusrcb_b), .pcsrc(pcsrc_b),
      .alucontrol(alucontrol_b), .instr_done(done_b), .illegal(illegal_b),
      .dbg_state(state_b)
   );

   wire [16:0] outs_a = {pcen_a, iord_a, irwrite_a, memwrite_a, regdst_a, memtoreg_a,
                         regwrite_a, alusrca_a, alusrcb_a, pcsrc_a, alucontrol_a,
                         done_a, illegal_a};
   wire [16:0] outs_b = {pcen_b, iord_b, irwrite_b, memwrite_b, regdst_b, memtoreg_b,
                         regwrite_b, alusrca_b, alusrcb_b, pcsrc_b, alucontrol_b,
                         done_b, illegal_b};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit supported(input logic [5:0] o, input bit bne_en);
      return (o == 6'h23) || (o == 6'h2B) || (o == 6'h00) || (o == 6'h04) ||
             (o == 6'h08) || (o == 6'h02) || (bne_en && (o == 6'h05));
   endfunction

   // State walk of one instruction, from its cycles-per-instruction class.
   function automatic int_q_t expected_seq(input logic [5:0] o, input bit bne_en);
      int_q_t q;
      q = '{0, 1};
      if (supported(o, bne_en)) begin
         case (o)
            6'h23:        q = '{0, 1, 2, 3, 4};
            6'h2B:        q = '{0, 1, 2, 5};
            6'h00:        q = '{0, 1, 6, 7};
            6'h08:        q = '{0, 1, 9, 10};
            6'h02:        q = '{0, 1, 11};
            default:      q = '{0, 1, 8};
         endcase
      end
      return q;
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'd32:   return 3'b010;
         6'd34:   return 3'b110;
         6'd36:   return 3'b000;
         6'd37:   return 3'b001;
         6'd42:   return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [16:0] exp_outs(input int st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input bit bne_en, input bit rst);
      logic pc = 0, io = 0, ir = 0, mw = 0, rd = 0, mr = 0, rw = 0, sa = 0, dn = 0, il = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] al = 3'b010;
      case (st)
         0:  begin ir = 1; pc = 1; sb = 2'b01; end
         1:  begin
                sb = 2'b11;
                if (!supported(o, bne_en)) begin il = 1; dn = 1; end
             end
         2:  begin sa = 1; sb = 2'b10; end
         3:  io = 1;
         4:  begin mr = 1; rw = 1; dn = 1; end
         5:  begin io = 1; mw = 1; dn = 1; end
         6:  begin sa = 1; al = funct_alu(f); end
         7:  begin rd = 1; rw = 1; dn = 1; end
         8:  begin
                sa = 1; al = 3'b110; ps = 2'b01; dn = 1;
                pc = z ^ (bne_en && (o == 6'h05));
             end
         9:  begin sa = 1; sb = 2'b10; end
         10: begin rw = 1; dn = 1; end
         11: begin ps = 2'b10; pc = 1; dn = 1; end
         default: ;
      endcase
      if (rst) begin pc = 0; ir = 0; rw = 0; mw = 0; dn = 0; il = 0; end
      return {pc, io, ir, mw, rd, mr, rw, sa, sb, ps, al, dn, il};
   endfunction

   task automatic check_cycle(input bit sel, input int st, input logic [5:0] o,
                              input logic [5:0] f, input logic z, input bit rst);
      logic [16:0] obs = sel ? outs_b : outs_a;
      logic [3:0]  sto = sel ? state_b : state_a;
      check($sformatf("dut%0d state op=%02h", sel, o), 32'(sto), 32'(st));
      check($sformatf("dut%0d outs st=%0d op=%02h fn=%02h z=%0d", sel, st, o, f, z),
            32'(obs), 32'(exp_outs(st, o, f, z, sel, rst)));
   endtask

   // Must be entered between a posedge and the following negedge with DUT in FETCH.
   task automatic run_instr(input bit sel, input logic [5:0] o, input logic [5:0] f,
                            input logic z);
      int_q_t q = expected_seq(o, sel);
      foreach (q[i]) begin
         @(negedge clk);
         if (i == 0) begin
            op = o; funct = f; zero = z;
         end
         #1;
         check_cycle(sel, q[i], o, f, z, 1'b0);
      end
   endtask

   task automatic run_random(input bit sel, input int n);
      logic [5:0] ops [8] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};
      logic [5:0] fns [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
      for (int k = 0; k < n; k++) begin
         logic [5:0] o, f;
         int pick = $urandom_range(0, 9);
         o = (pick < 8) ? ops[pick] : 6'($urandom);
         f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
         run_instr(sel, o, f, 1'($urandom));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      // Reset held three cycles, outputs at FETCH values with enables forced low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check_cycle(1'b0, 0, op, funct, zero, 1'b1);
      end
      @(posedge clk); #1 reset_a = 1'b0;

      run_instr(1'b0, 6'h23, 6'd0,  1'b0);
      run_instr(1'b0, 6'h00, 6'd42, 1'b0);
      run_instr(1'b0, 6'h2B, 6'd0,  1'b1);
      run_instr(1'b0, 6'h04, 6'd0,  1'b1);
      run_instr(1'b0, 6'h04, 6'd0,  1'b0);
      run_instr(1'b0, 6'h3F, 6'd0,  1'b0);
      run_instr(1'b0, 6'h05, 6'd0,  1'b1);
      run_instr(1'b0, 6'h08, 6'd0,  1'b0);
      run_instr(1'b0, 6'h02, 6'd0,  1'b0);
      run_instr(1'b0, 6'h00, 6'h3F, 1'b0);
      run_random(1'b0, 150);

      // Asynchronous abort during MEMWB of a load.
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (s == 0) begin op = 6'h23; funct = 6'd0; zero = 1'b0; end
         #1;
         check_cycle(1'b0, s, 6'h23, 6'd0, 1'b0, 1'b0);
      end
      #2 reset_a = 1'b1;
      #1;
      check("regwrite drop on async reset", 32'(regwrite_a), 32'd0);
      check_cycle(1'b0, 0, 6'h23, 6'd0, 1'b0, 1'b1);
      @(posedge clk); #1 reset_a = 1'b0;
      run_instr(1'b0, 6'h23, 6'd0, 1'b0);
      run_instr(1'b0, 6'h00, 6'd34, 1'b0);

      // Second instance decodes bne as an inverted branch.
      @(posedge clk); #1 reset_a = 1'b1;
      @(posedge clk); #1 reset_b = 1'b0;
      run_instr(1'b1, 6'h05, 6'd0, 1'b1);
      run_instr(1'b1, 6'h05, 6'd0, 1'b0);
      run_instr(1'b1, 6'h04, 6'd0, 1'b1);
      run_instr(1'b1, 6'h3F, 6'd0, 1'b0);
      run_random(1'b1, 120);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
